id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe.sv | 180 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage with register file and ID/EX pipeline register, including load-use bubble insertion.
// Optional macro ID_BYPASS_EN forwards same-cycle write-back data into operand capture and held operands.
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [XLEN-1:0]       i_pc,
    input  logic                  i_flush,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_pc,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    output logic [XLEN-1:0]       o_imm,
    output logic [REG_ADDR_W-1:0] o_rs1,
    output logic [REG_ADDR_W-1:0] o_rs2,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [15:0]           o_ctrl,
    output logic [CNT_W-1:0]      o_stall_cnt
);
    localparam int NUM_REGS = 2**REG_ADDR_W;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} id_state_t;

    id_state_t             state;
    logic [XLEN-1:0]       regs [NUM_REGS];
    logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [15:0]           dec_ctrl;
    logic [31:0]           imm32;
    logic [XLEN-1:0]       rs1_val, rs2_val;
    logic                  hazard, accept;

    logic       reg_write, alu_src, mem_write, mem_read, branch, mem_to_reg, sltc, start_dsp;
    logic [2:0] alu_control;
    logic [1:0] branch_op, op_dsp;

    assign dec_rs1 = i_instr[15 +: REG_ADDR_W];
    assign dec_rs2 = i_instr[20 +: REG_ADDR_W];
    assign dec_rd  = i_instr[7 +: REG_ADDR_W];

    always_comb begin
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        branch      = 1'b0;
        mem_to_reg  = 1'b0;
        sltc        = 1'b0;
        alu_control = 3'b000;
        branch_op   = 2'b00;
        start_dsp   = 1'b0;
        op_dsp      = 2'b00;
        imm32       = 32'h0;
        case (i_instr[6:0])
            7'b0110011, 7'b0010011: begin
                reg_write = 1'b1;
                alu_src   = (i_instr[6:0] == 7'b0010011);
                if (!alu_src)
                    imm32 = 32'h0;
                else
                    imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                case (i_instr[14:12])
                    3'b000:  alu_control = (!alu_src && i_instr[30]) ? 3'b001 : 3'b000;
                    3'b111:  alu_control = 3'b010;
                    3'b110:  alu_control = 3'b011;
                    3'b100:  alu_control = 3'b100;
                    3'b010:  alu_control = 3'b101;
                    3'b011: begin
                        alu_control = 3'b101;
                        sltc        = 1'b1;
                    end
                    3'b001:  alu_control = 3'b110;
                    default: alu_control = 3'b111;
                endcase
            end
            7'b0000011: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                imm32      = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            7'b0100011: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                imm32     = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            7'b1100011: begin
                branch      = 1'b1;
                alu_control = 3'b001;
                branch_op   = {i_instr[14], i_instr[12]};
                imm32       = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b0110111: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm32     = {i_instr[31:12], 12'h000};
            end
            // custom-0 opcode drives the DSP unit; funct3[1:0] selects its operation
            7'b0001011: begin
                reg_write = 1'b1;
                start_dsp = 1'b1;
                op_dsp    = i_instr[13:12];
            end
            default: ;
        endcase
        dec_ctrl = {1'b0, reg_write, alu_src, mem_write, mem_read, branch, mem_to_reg,
                    sltc, alu_control, branch_op, start_dsp, op_dsp};
    end

    always_comb begin
        rs1_val = (dec_rs1 == '0) ? '0 : regs[dec_rs1];
        rs2_val = (dec_rs2 == '0) ? '0 : regs[dec_rs2];
`ifdef ID_BYPASS_EN
        if (i_wb_we && i_wb_rd != '0 && i_wb_rd == dec_rs1) rs1_val = i_wb_data;
        if (i_wb_we && i_wb_rd != '0 && i_wb_rd == dec_rs2) rs2_val = i_wb_data;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (i_wb_we && i_wb_rd != '0) begin
            regs[i_wb_rd] <= i_wb_data;
        end
    end

    assign o_valid = (state == FULL);
    assign hazard  = o_valid && o_ctrl[11] && (o_rd != '0) &&
                     ((o_rd == dec_rs1) || (o_rd == dec_rs2));
    assign o_ready = i_reset && !i_flush && !hazard && (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;

    // Flush outranks everything; a hazard with EX ready drains the load and leaves a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= EMPTY;
            o_pc        <= '0;
            o_rs1_data  <= '0;
            o_rs2_data  <= '0;
            o_imm       <= '0;
            o_rs1       <= '0;
            o_rs2       <= '0;
            o_rd        <= '0;
            o_ctrl      <= '0;
            o_stall_cnt <= '0;
        end else if (i_flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state      <= FULL;
            o_pc       <= i_pc;
            o_rs1_data <= rs1_val;
            o_rs2_data <= rs2_val;
            o_imm      <= XLEN'($signed(imm32));
            o_rs1      <= dec_rs1;
            o_rs2      <= dec_rs2;
            o_rd       <= dec_rd;
            o_ctrl     <= dec_ctrl;
        end else if (state == FULL && i_ready) begin
            state <= EMPTY;
            if (hazard && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end else if (state == FULL) begin
`ifdef ID_BYPASS_EN
            if (i_wb_we && i_wb_rd != '0 && i_wb_rd == o_rs1) o_rs1_data <= i_wb_data;
            if (i_wb_we && i_wb_rd != '0 && i_wb_rd == o_rs2) o_rs2_data <= i_wb_data;
`endif
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: write-back, decode capture, load-use bubble, hold, flush, x0 and reset.
// Expected operand values follow the ID_BYPASS_EN macro when it is defined for the build.
module tb_id_stage_pipe;
    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, o_ready, i_flush, i_wb_we, o_valid, i_ready;
    logic [31:0] i_instr, i_pc, i_wb_data;
    logic [4:0]  i_wb_rd, o_rs1, o_rs2, o_rd;
    logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [15:0] o_ctrl, o_stall_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

`ifdef ID_BYPASS_EN
    localparam logic [31:0] HELD_X7  = 32'h77;
    localparam logic [31:0] SAME_X3  = 32'hBEEF;
`else
    localparam logic [31:0] HELD_X7  = 32'h0;
    localparam logic [31:0] SAME_X3  = 32'h1111;
`endif

    id_stage_pipe dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_ctrl(o_ctrl), .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ready, input logic flush, input logic we,
                                 input logic [4:0] rd, input logic [31:0] data);
        i_valid   = valid;
        i_instr   = instr;
        i_pc      = pc;
        i_ready   = ready;
        i_flush   = flush;
        i_wb_we   = we;
        i_wb_rd   = rd;
        i_wb_data = data;
        #1;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        checkOutput("reset_valid", o_valid, 0);
        checkOutput("reset_ready", o_ready, 0);
        checkOutput("reset_stall", o_stall_cnt, 0);
        checkOutput("reset_pc", o_pc, 0);
        i_reset = 1'b1;

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
        step();
        applyStimulus(1'b1, 32'h00028333, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("add_ready", o_ready, 1);
        step();
        checkOutput("add_valid", o_valid, 1);
        checkOutput("add_rs1_data", o_rs1_data, 32'h1234);
        checkOutput("add_rs2_data", o_rs2_data, 0);
        checkOutput("add_rd", o_rd, 6);
        checkOutput("add_pc", o_pc, 32'h100);
        checkOutput("add_ctrl", o_ctrl, 16'h4000);

        applyStimulus(1'b1, 32'hFFC0A383, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("lw_ready", o_ready, 1);
        step();
        checkOutput("lw_valid", o_valid, 1);
        checkOutput("lw_rd", o_rd, 7);
        checkOutput("lw_imm", o_imm, 32'hFFFFFFFC);
        checkOutput("lw_ctrl", o_ctrl, 16'h6A00);
        applyStimulus(1'b1, 32'h00138433, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("hazard_ready", o_ready, 0);
        step();
        checkOutput("bubble_valid", o_valid, 0);
        checkOutput("bubble_stall", o_stall_cnt, 1);
        checkOutput("after_bubble_ready", o_ready, 1);
        step();
        checkOutput("use_valid", o_valid, 1);
        checkOutput("use_rd", o_rd, 8);
        checkOutput("use_pc", o_pc, 32'h108);
        checkOutput("use_stall", o_stall_cnt, 1);

        applyStimulus(1'b1, 32'h405304B3, 32'h10C, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77);
        checkOutput("hold_ready", o_ready, 0);
        step();
        applyStimulus(1'b1, 32'h405304B3, 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int c = 0; c < 3; c++) step();
        checkOutput("hold_valid", o_valid, 1);
        checkOutput("hold_pc", o_pc, 32'h108);
        checkOutput("hold_rd", o_rd, 8);
        checkOutput("hold_ctrl", o_ctrl, 16'h4000);
        checkOutput("hold_rs1_data", o_rs1_data, HELD_X7);
        checkOutput("hold_ready_end", o_ready, 0);
        applyStimulus(1'b1, 32'h405304B3, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("release_ready", o_ready, 1);
        step();
        checkOutput("sub_valid", o_valid, 1);
        checkOutput("sub_rd", o_rd, 9);
        checkOutput("sub_ctrl", o_ctrl, 16'h4020);
        checkOutput("sub_rs2_data", o_rs2_data, 32'h1234);

        applyStimulus(1'b1, 32'h00028333, 32'h200, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        checkOutput("flush_ready", o_ready, 0);
        step();
        checkOutput("flush_valid", o_valid, 0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        checkOutput("flush_dropped", o_valid, 0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1111);
        step();
        applyStimulus(1'b1, 32'h00318233, 32'h300, 1'b1, 1'b0, 1'b1, 5'd3, 32'hBEEF);
        step();
        checkOutput("samecyc_rs1", o_rs1_data, SAME_X3);
        checkOutput("samecyc_rs2", o_rs2_data, SAME_X3);
        applyStimulus(1'b1, 32'h00318233, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        checkOutput("later_rs1", o_rs1_data, 32'hBEEF);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF);
        step();
        applyStimulus(1'b1, 32'h00000333, 32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        checkOutput("x0_rs1", o_rs1_data, 0);
        checkOutput("x0_rs2", o_rs2_data, 0);

        applyStimulus(1'b1, 32'h00028333, 32'h500, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        i_reset = 1'b0;
        #1;
        checkOutput("rst_low_ready", o_ready, 0);
        step();
        checkOutput("rst_hold_valid", o_valid, 0);
        checkOutput("rst_hold_stall", o_stall_cnt, 0);
        checkOutput("rst_hold_pc", o_pc, 0);
        i_reset = 1'b1;
        applyStimulus(1'b1, 32'h00028333, 32'h600, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("post_rst_ready", o_ready, 1);
        step();
        checkOutput("post_rst_valid", o_valid, 1);
        checkOutput("post_rst_pc", o_pc, 32'h600);
        checkOutput("post_rst_x5", o_rs1_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
